aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_round_cnt.sv | 26 ++
 rtl/aes_round_ctrl.sv | 98 +++++++++
 tb/tb_aes_round_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES control definitions: state-mux selects, controller FSM states, round counts per key size.
package aes_pkg;

    localparam logic [1:0] SEL_INIT  = 2'b00;
    localparam logic [1:0] SEL_ROUND = 2'b01;
    localparam logic [1:0] SEL_FINAL = 2'b11;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/aes_round_cnt.sv
// Round index register with load-to-1, increment, clear and hold; updates one edge after its command.
// No backpressure: the controller issues at most one command per cycle.
module aes_round_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= {{(W-1){1'b0}}, 1'b1};
        end else if (inc) begin
            cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steers the state mux and registers its output; done NR+1 edges after start.
// Result is held on state_q with done high until out_ready; start is only sampled in IDLE.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int NR = NR_128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] mux_out,
    input  logic         out_ready,
    output logic [1:0]   sel,
    output logic [3:0]   round,
    output logic [N-1:0] state_q,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LAST_RND = 4'(NR - 1);

    state_t cur_st;
    state_t nxt_st;
    logic   cap_en;
    logic   cnt_load;
    logic   cnt_inc;
    logic   cnt_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st  <= IDLE;
            state_q <= '0;
        end else begin
            cur_st <= nxt_st;
            if (cap_en) begin
                state_q <= mux_out;
            end
        end
    end

    // Outputs decode from the registered state only, so mux_out never reaches an output combinationally.
    always_comb begin
        nxt_st   = cur_st;
        sel      = SEL_INIT;
        busy     = 1'b1;
        done     = 1'b0;
        cap_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        cnt_clr  = 1'b0;
        case (cur_st)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    cap_en   = 1'b1;
                    cnt_load = 1'b1;
                    nxt_st   = ROUND;
                end
            end
            ROUND: begin
                sel     = SEL_ROUND;
                cap_en  = 1'b1;
                cnt_inc = 1'b1;
                if (round == LAST_RND) begin
                    nxt_st = FINAL;
                end
            end
            FINAL: begin
                sel    = SEL_FINAL;
                cap_en = 1'b1;
                nxt_st = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (out_ready) begin
                    cnt_clr = 1'b1;
                    nxt_st  = IDLE;
                end
            end
            default: begin
                nxt_st = IDLE;
            end
        endcase
    end

    aes_round_cnt #(
        .W(4)
    ) u_round_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .cnt   (round)
    );

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl at NR=10 and NR=14: block-position reference model plus directed scenarios.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   st = 2'b00;
    logic [1:0]   ordy = 2'b11;
    logic [127:0] mux_w [2];
    logic [1:0]   sel_o [2];
    logic [3:0]   rnd_o [2];
    logic [127:0] q_o [2];
    logic         busy_o [2];
    logic         done_o [2];

    int n_chk = 0;
    int n_fail = 0;

    int           nrv [2] = '{NR_128, NR_256};
    int           cap [2];
    logic [127:0] mst [2];

    always #5 clk = ~clk;

    function automatic logic [127:0] mux_f(input logic [1:0] s, input logic [127:0] q);
        case (s)
            2'b00:   return 128'h1;
            2'b01:   return q + 128'h1;
            2'b11:   return ~q;
            default: return 128'h0;
        endcase
    endfunction

    assign mux_w[0] = mux_f(sel_o[0], q_o[0]);
    assign mux_w[1] = mux_f(sel_o[1], q_o[1]);

    aes_round_ctrl #(.N(128), .NR(NR_128)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .mux_out(mux_w[0]), .out_ready(ordy[0]),
        .sel(sel_o[0]), .round(rnd_o[0]), .state_q(q_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    aes_round_ctrl #(.N(128), .NR(NR_256)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .mux_out(mux_w[1]), .out_ready(ordy[1]),
        .sel(sel_o[1]), .round(rnd_o[1]), .state_q(q_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    // Model: cap = number of mux captures made in the current block (0 = idle, NR+1 = result held).
    function automatic logic [1:0] m_sel(input int d);
        if (cap[d] >= 1 && cap[d] <= nrv[d] - 1) return 2'b01;
        if (cap[d] == nrv[d]) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_round(input int d);
        if (cap[d] == 0) return 4'd0;
        if (cap[d] <= nrv[d]) return 4'(cap[d]);
        return 4'(nrv[d]);
    endfunction

    function automatic bit m_capture(input int d);
        return (cap[d] == 0 && st[d]) || (cap[d] >= 1 && cap[d] <= nrv[d]);
    endfunction

    function automatic int m_next(input int d);
        if (cap[d] == 0) return st[d] ? 1 : 0;
        if (cap[d] <= nrv[d]) return cap[d] + 1;
        return ordy[d] ? 0 : cap[d];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                cap[d] <= 0;
                mst[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_capture(d)) mst[d] <= mux_f(m_sel(d), mst[d]);
                cap[d] <= m_next(d);
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("model_sel%0d", d), 128'(sel_o[d]), 128'(m_sel(d)));
                chk($sformatf("model_round%0d", d), 128'(rnd_o[d]), 128'(m_round(d)));
                chk($sformatf("model_busy%0d", d), 128'(busy_o[d]), 128'(cap[d] != 0));
                chk($sformatf("model_done%0d", d), 128'(done_o[d]), 128'(cap[d] == nrv[d] + 1));
                chk($sformatf("model_state%0d", d), q_o[d], mst[d]);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_sel%0d", tag, d), 128'(sel_o[d]), 128'h0);
            chk($sformatf("%s_round%0d", tag, d), 128'(rnd_o[d]), 128'h0);
            chk($sformatf("%s_busy%0d", tag, d), 128'(busy_o[d]), 128'h0);
            chk($sformatf("%s_done%0d", tag, d), 128'(done_o[d]), 128'h0);
            chk($sformatf("%s_state%0d", tag, d), q_o[d], 128'h0);
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy_o[d] !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 128'(busy_o[d]), 128'h0);
    endtask

    // Called one time unit after a rising edge with DUT d idle.
    task automatic run_block(input int d, input int nr, input logic [127:0] exp_q,
                             input bit bp, input bit hold);
        logic [1:0] seq [$];
        logic [1:0] e;
        int n = 0;
        int s11 = 0;
        int peak = 0;
        ordy[d] = !bp;
        st[d] = 1'b1;
        seq.push_back(sel_o[d]);
        while (done_o[d] !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!hold) st[d] = 1'b0;
            seq.push_back(sel_o[d]);
            if (sel_o[d] == 2'b11) s11++;
            if (int'(rnd_o[d]) > peak) peak = int'(rnd_o[d]);
        end
        chk("latency", 128'(n), 128'(nr + 1));
        chk("result", q_o[d], exp_q);
        chk("round_at_done", 128'(rnd_o[d]), 128'(nr));
        chk("round_peak", 128'(peak), 128'(nr));
        chk("final_cycles", 128'(s11), 128'h1);
        chk("seq_len", 128'(seq.size()), 128'(nr + 2));
        for (int i = 0; i < seq.size() && i < nr + 2; i++) begin
            e = (i == 0 || i == nr + 1) ? 2'b00 : ((i == nr) ? 2'b11 : 2'b01);
            chk($sformatf("sel_seq[%0d]", i), 128'(seq[i]), 128'(e));
        end
        if (bp) begin
            repeat (5) begin
                @(posedge clk); #1;
                chk("bp_done", 128'(done_o[d]), 128'h1);
                chk("bp_state", q_o[d], exp_q);
                chk("bp_round", 128'(rnd_o[d]), 128'(nr));
            end
            ordy[d] = 1'b1;
        end
        @(posedge clk); #1;
        chk("idle_busy", 128'(busy_o[d]), 128'h0);
        chk("idle_done", 128'(done_o[d]), 128'h0);
        chk("idle_round", 128'(rnd_o[d]), 128'h0);
        chk("idle_state_held", q_o[d], exp_q);
        if (hold) begin
            @(posedge clk); #1;
            chk("restart_busy", 128'(busy_o[d]), 128'h1);
            chk("restart_round", 128'(rnd_o[d]), 128'h1);
            st[d] = 1'b0;
            wait_idle(d);
        end
    endtask

    initial begin
        bit saw_done;
        int n;

        @(posedge clk); #1;
        chk_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("post_reset_idle");

        run_block(0, 10, ~128'hA, 1'b0, 1'b0);
        run_block(0, 10, ~128'hA, 1'b1, 1'b0);
        run_block(0, 10, ~128'hA, 1'b0, 1'b1);
        run_block(1, 14, ~128'hE, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a block.
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        n = 0;
        while (rnd_o[0] !== 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_round5", 128'(rnd_o[0]), 128'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        chk_all_zero("reset_held");
        #3;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_o[0] || busy_o[0]) saw_done = 1'b1;
        end
        chk("no_done_after_reset", 128'(saw_done), 128'h0);
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        chk("first_start_busy", 128'(busy_o[0]), 128'h1);
        chk("first_start_round", 128'(rnd_o[0]), 128'h1);
        chk("first_start_state", q_o[0], 128'h1);
        wait_idle(0);

        // Random traffic on both instances with occasional asynchronous reset pulses.
        repeat (1500) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            for (int d = 0; d < 2; d++) begin
                st[d]   = ($urandom_range(0, 3) == 0);
                ordy[d] = 1'($urandom_range(0, 1));
            end
        end
        st = 2'b00;
        ordy = 2'b11;
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
